// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x DATA_W register file with one write port, two
// registered read ports, write-to-read bypass and a sequenced bulk clear.
// Optional build macro ZERO_REG_EN: entry 0 hard-wired to zero.
module reg_file_param #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok_c;
  logic              byp0_c;
  logic              byp1_c;
  logic [DATA_W-1:0] rd0_mem_c;
  logic [DATA_W-1:0] rd1_mem_c;

  // Clear-engine state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      clr_busy <= (state_next == CLEAR);
    end
  end

  // Clear-engine next state: walk cnt over every entry once, ignore clr_req while busy.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST_IDX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Write acceptance and per-port bypass detection.
  always_comb begin
    wr_ok_c = wr_en && !clr_busy && ({1'b0, wr_addr} < DEPTH_EXT);
    if (ZERO_REG && (wr_addr == '0)) begin
      wr_ok_c = 1'b0;
    end
    byp0_c = wr_ok_c && (rd0_addr == wr_addr);
    byp1_c = wr_ok_c && (rd1_addr == wr_addr);
  end

  // Array lookup for both read ports; unmapped addresses yield zero.
  always_comb begin
    rd0_mem_c = '0;
    rd1_mem_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd0_addr == ADDR_W'(i)) begin
        rd0_mem_c = mem[i];
      end
      if (rd1_addr == ADDR_W'(i)) begin
        rd1_mem_c = mem[i];
      end
    end
  end

  // Storage array: clear engine owns the entry at cnt, otherwise accepted writes land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ZERO_REG && (i == 0)) begin
          mem[i] <= '0;
        end else if ((state == CLEAR) && (cnt == ADDR_W'(i))) begin
          mem[i] <= '0;
        end else if (wr_ok_c && (wr_addr == ADDR_W'(i))) begin
          mem[i] <= wr_data;
        end
      end
    end
  end

  // Registered read port 0: load on enable (bypass first), hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_data  <= '0;
      rd0_valid <= 1'b0;
    end else begin
      rd0_valid <= rd0_en;
      if (rd0_en) begin
        rd0_data <= byp0_c ? wr_data : rd0_mem_c;
      end
    end
  end

  // Registered read port 1: load on enable (bypass first), hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd1_valid <= rd1_en;
      if (rd1_en) begin
        rd1_data <= byp1_c ? wr_data : rd1_mem_c;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed vector table plus hand-written clear, reset
// and out-of-range sequences for reg_file_param.
module tb_reg_file_param;

  logic       clk;
  logic       rst;
  logic       clr_req;
  logic       clr_busy;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [8:0] wr_data;
  logic       rd0_en;
  logic [1:0] rd0_addr;
  logic [8:0] rd0_data;
  logic       rd0_valid;
  logic       rd1_en;
  logic [1:0] rd1_addr;
  logic [8:0] rd1_data;
  logic       rd1_valid;

  // Second instance with DEPTH=3 for out-of-range behaviour.
  logic       d3_clr_req;
  logic       d3_clr_busy;
  logic       d3_wr_en;
  logic [1:0] d3_wr_addr;
  logic [8:0] d3_wr_data;
  logic       d3_rd0_en;
  logic [1:0] d3_rd0_addr;
  logic [8:0] d3_rd0_data;
  logic       d3_rd0_valid;
  logic       d3_rd1_en;
  logic [1:0] d3_rd1_addr;
  logic [8:0] d3_rd1_data;
  logic       d3_rd1_valid;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ZERO_REG_EN
  localparam logic [8:0] E0_55 = 9'd0;
  localparam logic [8:0] E0_99 = 9'd0;
`else
  localparam logic [8:0] E0_55 = 9'd55;
  localparam logic [8:0] E0_99 = 9'd99;
`endif

  reg_file_param #(.DATA_W(9), .ADDR_W(2), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid)
  );

  reg_file_param #(.DATA_W(9), .ADDR_W(2), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .clr_req(d3_clr_req), .clr_busy(d3_clr_busy),
    .wr_en(d3_wr_en), .wr_addr(d3_wr_addr), .wr_data(d3_wr_data),
    .rd0_en(d3_rd0_en), .rd0_addr(d3_rd0_addr), .rd0_data(d3_rd0_data), .rd0_valid(d3_rd0_valid),
    .rd1_en(d3_rd1_en), .rd1_addr(d3_rd1_addr), .rd1_data(d3_rd1_data), .rd1_valid(d3_rd1_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [8:0] wr_data;
    logic       rd0_en;
    logic [1:0] rd0_addr;
    logic       rd1_en;
    logic [1:0] rd1_addr;
    logic [8:0] e0;
    logic       ev0;
    logic [8:0] e1;
    logic       ev1;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input int we, input int wa, input int wd,
                              input int r0e, input int r0a, input int r1e, input int r1a,
                              input int e0, input int ev0, input int e1, input int ev1);
    vec_t v;
    v.wr_en    = 1'(we);
    v.wr_addr  = 2'(wa);
    v.wr_data  = 9'(wd);
    v.rd0_en   = 1'(r0e);
    v.rd0_addr = 2'(r0a);
    v.rd1_en   = 1'(r1e);
    v.rd1_addr = 2'(r1a);
    v.e0       = 9'(e0);
    v.ev0      = 1'(ev0);
    v.e1       = 9'(e1);
    v.ev1      = 1'(ev1);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr_req  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 9'd0;
    rd0_en   = 1'b0;
    rd0_addr = 2'd0;
    rd1_en   = 1'b0;
    rd1_addr = 2'd0;
  endtask

  task automatic d3_idle();
    d3_clr_req  = 1'b0;
    d3_wr_en    = 1'b0;
    d3_wr_addr  = 2'd0;
    d3_wr_data  = 9'd0;
    d3_rd0_en   = 1'b0;
    d3_rd0_addr = 2'd0;
    d3_rd1_en   = 1'b0;
    d3_rd1_addr = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    d3_idle();
    rst = 1'b1;
    #1;
    check("reset clr_busy", 32'(clr_busy), 0);
    check("reset rd0_data", 32'(rd0_data), 0);
    check("reset rd0_valid", 32'(rd0_valid), 0);
    check("reset rd1_data", 32'(rd1_data), 0);
    check("reset rd1_valid", 32'(rd1_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //          we wa wd   r0e r0a r1e r1a  e0     ev0 e1   ev1
    vecs[0]  = mk(0, 0, 0,   1,  2,  1,  3,  0,     1,  0,   1);
    vecs[1]  = mk(1, 0, 55,  0,  0,  0,  0,  0,     0,  0,   0);
    vecs[2]  = mk(1, 1, 25,  0,  0,  0,  0,  0,     0,  0,   0);
    vecs[3]  = mk(1, 2, 30,  0,  0,  0,  0,  0,     0,  0,   0);
    vecs[4]  = mk(1, 3, 80,  0,  0,  0,  0,  0,     0,  0,   0);
    vecs[5]  = mk(0, 0, 0,   1,  2,  1,  3,  30,    1,  80,  1);
    vecs[6]  = mk(0, 0, 0,   0,  0,  0,  0,  30,    0,  80,  0);
    vecs[7]  = mk(1, 1, 400, 1,  1,  1,  1,  400,   1,  400, 1);
    vecs[8]  = mk(0, 0, 0,   1,  1,  1,  0,  400,   1,  E0_55, 1);
    vecs[9]  = mk(1, 2, 511, 1,  3,  1,  2,  80,    1,  511, 1);
    vecs[10] = mk(1, 0, 99,  1,  0,  1,  2,  E0_99, 1,  511, 1);
    vecs[11] = mk(0, 0, 0,   1,  0,  0,  0,  E0_99, 1,  511, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_en    = vecs[i].wr_en;
      wr_addr  = vecs[i].wr_addr;
      wr_data  = vecs[i].wr_data;
      rd0_en   = vecs[i].rd0_en;
      rd0_addr = vecs[i].rd0_addr;
      rd1_en   = vecs[i].rd1_en;
      rd1_addr = vecs[i].rd1_addr;
      tick();
      check($sformatf("vec%0d rd0_data", i), 32'(rd0_data), 32'(vecs[i].e0));
      check($sformatf("vec%0d rd0_valid", i), 32'(rd0_valid), 32'(vecs[i].ev0));
      check($sformatf("vec%0d rd1_data", i), 32'(rd1_data), 32'(vecs[i].e1));
      check($sformatf("vec%0d rd1_valid", i), 32'(rd1_valid), 32'(vecs[i].ev1));
    end

    // Clear: request at edge T together with a write of 123 to addr 3.
    @(negedge clk);
    idle_inputs();
    clr_req = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 9'd123;
    tick();
    check("clear busy T", 32'(clr_busy), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      clr_req  = (k <= 3);
      wr_en    = 1'b1;
      wr_addr  = 2'd0;
      wr_data  = 9'd5;
      rd0_en   = (k >= 3);
      rd0_addr = 2'd3;
      rd1_en   = (k == 3);
      rd1_addr = 2'd0;
      tick();
      check($sformatf("clear busy T+%0d", k), 32'(clr_busy), (k < 4) ? 1 : 0);
      if (k >= 3) begin
        check($sformatf("clear rd0 addr3 T+%0d", k), 32'(rd0_data), 123);
      end
      if (k == 3) begin
        check("clear rd1 addr0 cleared", 32'(rd1_data), 0);
      end
    end
    @(negedge clk);
    idle_inputs();
    tick();
    check("clear no restart", 32'(clr_busy), 0);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      rd0_en   = 1'b1;
      rd0_addr = 2'(2 * p);
      rd1_en   = 1'b1;
      rd1_addr = 2'(2 * p + 1);
      tick();
      check($sformatf("post-clear entry%0d", 2 * p), 32'(rd0_data), 0);
      check($sformatf("post-clear entry%0d", 2 * p + 1), 32'(rd1_data), 0);
      check("post-clear busy", 32'(clr_busy), 0);
    end

    // Async reset in the middle of a clear.
    @(negedge clk);
    idle_inputs();
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 9'd200;
    tick();
    @(negedge clk);
    idle_inputs();
    clr_req  = 1'b1;
    rd0_en   = 1'b1;
    rd0_addr = 2'd3;
    rd1_en   = 1'b1;
    rd1_addr = 2'd3;
    tick();
    @(negedge clk);
    clr_req = 1'b0;
    tick();
    tick();
    check("midclear busy T+2", 32'(clr_busy), 1);
    check("midclear rd0 T+2", 32'(rd0_data), 200);
    #2;
    rst = 1'b1;
    #1;
    check("rst async clr_busy", 32'(clr_busy), 0);
    check("rst async rd0_data", 32'(rd0_data), 0);
    check("rst async rd0_valid", 32'(rd0_valid), 0);
    check("rst async rd1_data", 32'(rd1_data), 0);
    check("rst async rd1_valid", 32'(rd1_valid), 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 2'd3;
    wr_data = 9'd321;
    tick();
    check("post-rst busy idle", 32'(clr_busy), 0);
    @(negedge clk);
    idle_inputs();
    rd0_en   = 1'b1;
    rd0_addr = 2'd3;
    rd1_en   = 1'b1;
    rd1_addr = 2'd2;
    tick();
    check("post-rst write accepted", 32'(rd0_data), 321);
    check("post-rst entry2 zero", 32'(rd1_data), 0);

    // DEPTH=3: out-of-range write dropped, out-of-range read returns 0.
    @(negedge clk);
    idle_inputs();
    d3_wr_en   = 1'b1;
    d3_wr_addr = 2'd2;
    d3_wr_data = 9'd45;
    tick();
    @(negedge clk);
    d3_wr_addr  = 2'd3;
    d3_wr_data  = 9'd7;
    d3_rd0_en   = 1'b1;
    d3_rd0_addr = 2'd3;
    d3_rd1_en   = 1'b1;
    d3_rd1_addr = 2'd2;
    tick();
    check("d3 oob bypass rd0", 32'(d3_rd0_data), 0);
    check("d3 oob rd0_valid", 32'(d3_rd0_valid), 1);
    check("d3 entry2 rd1", 32'(d3_rd1_data), 45);
    @(negedge clk);
    d3_idle();
    d3_rd0_en   = 1'b1;
    d3_rd0_addr = 2'd0;
    d3_rd1_en   = 1'b1;
    d3_rd1_addr = 2'd1;
    tick();
    check("d3 entry0 unchanged", 32'(d3_rd0_data), 0);
    check("d3 entry1 unchanged", 32'(d3_rd1_data), 0);
    @(negedge clk);
    d3_rd0_addr = 2'd3;
    d3_rd1_addr = 2'd2;
    tick();
    check("d3 oob read later", 32'(d3_rd0_data), 0);
    check("d3 entry2 later", 32'(d3_rd1_data), 45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
